// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands in a small FIFO and issues them one at a time to an
// external combinational 8-bit ALU. Each result is returned with the caller's tag.
//
// Ports:
//   clk, rst                        clock; synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready while the FIFO has room)
//   cmd_opA/cmd_opB/cmd_opS/cmd_tag command operands, opcode and caller tag
//   alu_opA/alu_opB/alu_opS         registered operands and opcode driven to the ALU
//   alu_result                      combinational ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_data/rsp_tag/rsp_err        result, tag, and illegal-opcode flag
//   busy                            FSM not idle or FIFO holds commands
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_opA,
  input  logic [7:0] cmd_opB,
  input  logic [3:0] cmd_opS,
  input  logic [1:0] cmd_tag,
  output logic [7:0] alu_opA,
  output logic [7:0] alu_opB,
  output logic [3:0] alu_opS,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_tag,
  output logic       rsp_err,
  output logic       busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [3:0]    mem_s [DEPTH];
  logic [1:0]    mem_t [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0] alu_s_q, alu_s_d;
  logic       err_q, err_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_tag_q, rsp_tag_d;
  logic       rsp_err_q, rsp_err_d;

  logic       push, pop, load, have_cmd;
  logic [7:0] head_a, head_b;
  logic [3:0] head_s;

  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready && !rst;
  // A command arriving on the same edge can be issued straight away when the FIFO is empty.
  assign have_cmd  = (count_q != '0) || push;
  assign head_a    = (count_q != '0) ? mem_a[rd_ptr_q] : cmd_opA;
  assign head_b    = (count_q != '0) ? mem_b[rd_ptr_q] : cmd_opB;
  assign head_s    = (count_q != '0) ? mem_s[rd_ptr_q] : cmd_opS;

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    pop        = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (have_cmd) begin
          load    = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        // Head entry is guaranteed present here: it was written no later than the load edge.
        rsp_data_d = err_q ? 8'h00 : alu_result;
        rsp_tag_d  = mem_t[rd_ptr_q];
        rsp_err_d  = err_q;
        pop        = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          if (have_cmd) begin
            load    = 1'b1;
            state_d = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      alu_a_d = head_a;
      alu_b_d = head_b;
      // Illegal opcodes are issued as NOP and flagged on the response.
      err_d   = (head_s > 4'd8);
      alu_s_d = (head_s > 4'd8) ? 4'd0 : head_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= cmd_opA;
      mem_b[wr_ptr_q] <= cmd_opB;
      mem_s[wr_ptr_q] <= cmd_opS;
      mem_t[wr_ptr_q] <= cmd_tag;
    end
  end

  assign alu_opA   = alu_a_q;
  assign alu_opB   = alu_b_q;
  assign alu_opS   = alu_s_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle) || (count_q != '0);

endmodule
